usr_serdes_ctrl: RTL and testbench
==================================

# usr_serdes_ctrl

Sequencer that drives a parameterized universal shift register (hold / shift-right / shift-left / parallel-load) as a full-duplex serial transceiver. It accepts a parallel word with a transfer length and direction over a valid/ready command port. It then shifts the word out serially while capturing serial input bits, and returns the captured word on a valid/ready response port. It sits between a parallel requester and a bit-serial link.

## Interface
- WIDTH, 4: shift register width in bits (≥2)
- LW, $clog2(WIDTH+1): width of the length field
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_dir  in  1  0 = MSB-first (shift left), 1 = LSB-first (shift right)
- cmd_len  in  LW  bits to transfer; 0 or >WIDTH means WIDTH
- cmd_data  in  WIDTH  word to transmit
- ser_out  out  1  serial transmit bit
- ser_in  in  1  serial receive bit, sampled on strobe cycles
- ser_strobe  out  1  high in each shift cycle
- rsp_valid  out  1  captured word available
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  WIDTH  shift register contents after the transfer
- busy  out  1  high when state ≠ IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1.
  - Core mode is HOLD, except on a handshake cycle, where it is LOAD with cmd_data.
  - A handshake latches cmd_dir, latches effective length into a down-counter, and moves to SHIFT.
- SHIFT:
  - cmd_ready = 0 and ser_strobe = 1.
  - Mode is SHL when dir = 0 and SHR when dir = 1.
  - ser_out is combinational: register MSB when dir = 0, LSB when dir = 1.
  - ser_in feeds the vacated end: LSB on SHL, MSB on SHR.
  - The counter decrements each cycle; on the cycle the counter equals 1, the FSM moves to DONE.
- DONE:
  - Mode is HOLD.
  - rsp_valid = 1 and rsp_data = register value, held stable until the handshake.
  - On rsp_ready the FSM moves to IDLE.
  - cmd_ready stays 0, so a new command is never accepted in the same cycle as the response.
- Partial length (len < WIDTH): untransferred bits remain in the register shifted toward the output end, and rsp_data reports the full register.
- ser_out in IDLE/DONE equals the register MSB (dir latch = 0 after reset). It is don't-care to consumers when ser_strobe = 0.
- Reset values: state IDLE, register 0, counter 0, dir 0, cmd_ready 1, rsp_valid 0, ser_strobe 0, busy 0, rsp_data 0, ser_out 0.
- Reset mid-transfer or in DONE aborts immediately. No response is produced for the aborted command.

## Timing
- Command handshake at edge E0 loads the register at E0.
- Strobe cycles occupy cycles 1..len after E0; bit k is sampled at edge Ek.
- rsp_valid rises in cycle len+1, so command-to-response latency is len+1 cycles.
- Minimum command period is len+2 cycles (with rsp_ready held high).
- Throughput with WIDTH=4 and full length: one word per 6 cycles.
- cmd_ready is a pure function of state (no combinational path from rsp_ready).

## Structure
- Package usr_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11;
  - state enum {IDLE, SHIFT, DONE};
  - direction constants DIR_MSB_FIRST=0, DIR_LSB_FIRST=1.
- Sub-module usr_core:
  - parameterized-WIDTH universal shift register;
  - ports clock, reset, mode[1:0], par_in, msb_in, lsb_in, q, msb_out, lsb_out;
  - synchronous active-high reset to 0.
- Controller: FSM, length counter, direction latch, and mode/serial-steering muxes around one usr_core instance.

## Test plan
- Reset: assert reset 2 cycles mid-SHIFT. Required: next cycle state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, no further strobes.
- MSB-first, full length: dir=0, len=0, data=4'b1010, ser_in=0. Required: ser_out 1,0,1,0 on 4 strobes, then rsp_data=4'b0000 with rsp_valid in cycle 5.
- Loopback: ser_in=ser_out, dir=1, len=4, data=4'b1101. Required: ser_out 1,0,1,1 and rsp_data=4'b1101.
- Partial length:
  - dir=0, len=2, data=4'b1100, ser_in=1. Required: ser_out 1,1, then rsp_data=4'b0011.
  - dir=1, len=2, data=4'b1100, ser_in=0. Required: ser_out 0,0, then rsp_data=4'b0011.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE while cmd_valid=1 with new data. Required: rsp_data stable, cmd_ready=0, and no load. After rsp_ready, the FSM returns to IDLE and the next command is accepted one cycle later.
- Length clamp: len=7 with WIDTH=4. Required: exactly 4 strobes.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal-shift-register serial transceiver.
//   - Core mode encodings driven into usr_core.
//   - Controller state enumeration.
//   - Transfer direction encodings carried on cmd_dir.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/usr_core.sv
// usr_core: parameterized universal shift register.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset, clears q
//   mode     in   HOLD / SHR / SHL / LOAD (see usr_pkg)
//   par_in   in   parallel load word
//   msb_in   in   bit entering at the MSB on shift-right
//   lsb_in   in   bit entering at the LSB on shift-left
//   q        out  register contents
//   msb_out  out  q[WIDTH-1]
//   lsb_out  out  q[0]
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] q,
    output logic             msb_out,
    output logic             lsb_out
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            case (mode)
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= {msb_in, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], lsb_in};
                MODE_LOAD: r_q <= par_in;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q       = r_q;
    assign msb_out = r_q[WIDTH-1];
    assign lsb_out = r_q[0];

endmodule

// File: rtl/usr_serdes_ctrl.sv
// usr_serdes_ctrl: full-duplex serial transceiver sequencer around one usr_core.
// A command word is parallel-loaded, shifted out MSB- or LSB-first for the
// requested number of bits while ser_in is shifted into the vacated end, and
// the resulting register contents are returned on the response port.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_dir                   0 = MSB-first (shift left), 1 = LSB-first (shift right)
//   cmd_len                   bits to transfer; 0 or >WIDTH means WIDTH
//   cmd_data                  word to transmit
//   ser_out / ser_in          serial transmit / receive bit
//   ser_strobe                high in each shift cycle
//   rsp_valid/rsp_ready       response handshake
//   rsp_data                  register contents after the transfer
//   busy                      high whenever not IDLE
module usr_serdes_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [LW-1:0]    cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             ser_strobe,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [LW-1:0] W_LEN = LW'(WIDTH);
    localparam logic [LW-1:0] W_ONE = LW'(1);

    state_t           r_state;
    logic [LW-1:0]    r_cnt;
    logic             r_dir;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic             r_strobe;
    logic             r_busy;

    logic             w_hs;
    logic [LW-1:0]    w_eff_len;
    logic [1:0]       w_mode;
    logic [WIDTH-1:0] w_q;
    logic             w_msb;
    logic             w_lsb;

    assign w_hs      = cmd_valid && (r_state == IDLE);
    assign w_eff_len = ((cmd_len == '0) || (cmd_len > W_LEN)) ? W_LEN : cmd_len;

    // Mode must be combinational so the load lands on the handshake edge itself.
    always_comb begin
        w_mode = MODE_HOLD;
        case (r_state)
            IDLE:    if (w_hs) w_mode = MODE_LOAD;
            SHIFT:   w_mode = (r_dir == DIR_LSB_FIRST) ? MODE_SHR : MODE_SHL;
            default: w_mode = MODE_HOLD;
        endcase
    end

    // Status outputs are registered alongside the state so each is a pure
    // function of state with no path from the handshake inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dir       <= DIR_MSB_FIRST;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_strobe    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= SHIFT;
                        r_dir       <= cmd_dir;
                        r_cnt       <= w_eff_len;
                        r_cmd_ready <= 1'b0;
                        r_strobe    <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    r_cnt <= r_cnt - W_ONE;
                    if (r_cnt == W_ONE) begin
                        r_state     <= DONE;
                        r_strobe    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_strobe    <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    usr_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .mode    (w_mode),
        .par_in  (cmd_data),
        .msb_in  (ser_in),
        .lsb_in  (ser_in),
        .q       (w_q),
        .msb_out (w_msb),
        .lsb_out (w_lsb)
    );

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign ser_strobe = r_strobe;
    assign busy       = r_busy;
    assign rsp_data   = w_q;
    assign ser_out    = (r_dir == DIR_LSB_FIRST) ? w_lsb : w_msb;

endmodule

// File: tb/tb_usr_serdes_ctrl.sv
// tb_usr_serdes_ctrl: directed self-checking bench for usr_serdes_ctrl (WIDTH=4).
module tb_usr_serdes_ctrl;

    localparam int WIDTH = 4;
    localparam int LW    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_dir;
    logic [LW-1:0]    cmd_len;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_out;
    logic             ser_in;
    logic             ser_strobe;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;

    usr_serdes_ctrl #(
        .WIDTH(WIDTH),
        .LW(LW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .ser_out    (ser_out),
        .ser_in     (ser_in),
        .ser_strobe (ser_strobe),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and walk its strobe cycles. exp_seq holds the expected
    // serial bits with the first transmitted bit in the MSB position.
    task automatic run_cmd(input string tag, input logic dir, input logic [LW-1:0] len,
                           input logic [WIDTH-1:0] data, input logic sin, input logic loop,
                           input logic [WIDTH-1:0] exp_seq, input int exp_n,
                           input logic [WIDTH-1:0] exp_rsp);
        int n;
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_len   = len;
        cmd_data  = data;
        ser_in    = sin;
        check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick;
        cmd_valid = 1'b0;
        n = 0;
        while (ser_strobe === 1'b1 && n < 12) begin
            if (n < WIDTH) check({tag, ".ser_out"}, 32'(ser_out), 32'(exp_seq[WIDTH-1-n]));
            ser_in = loop ? ser_out : sin;
            tick;
            n++;
        end
        check({tag, ".strobes"}, 32'(n), 32'(exp_n));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_rsp));
        check({tag, ".cmd_ready_done"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check({tag, ".rsp_valid_off"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        ser_in    = 1'b0;
        rsp_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;

        // Reset values
        check("rst.cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.strobe", 32'(ser_strobe), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rsp_data", 32'(rsp_data), 32'd0);
        check("rst.ser_out", 32'(ser_out), 32'd0);

        // Reset asserted for two cycles mid-SHIFT aborts the transfer
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_len   = 3'd4;
        cmd_data  = 4'b1111;
        tick;
        cmd_valid = 1'b0;
        check("abort.in_shift", 32'(ser_strobe), 32'd1);
        tick;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        check("abort.cmd_ready", 32'(cmd_ready), 32'd1);
        check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort.rsp_data", 32'(rsp_data), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort.no_strobe", 32'(ser_strobe), 32'd0);
            check("abort.no_rsp", 32'(rsp_valid), 32'd0);
            tick;
        end

        // MSB-first, len=0 means full width
        run_cmd("msb_full", 1'b0, 3'd0, 4'b1010, 1'b0, 1'b0, 4'b1010, 4, 4'b0000);
        release_rsp("msb_full");

        // LSB-first loopback returns the original word
        run_cmd("loopback", 1'b1, 3'd4, 4'b1101, 1'b0, 1'b1, 4'b1011, 4, 4'b1101);
        release_rsp("loopback");

        // Partial length, both directions
        run_cmd("part_msb", 1'b0, 3'd2, 4'b1100, 1'b1, 1'b0, 4'b1100, 2, 4'b0011);
        release_rsp("part_msb");
        run_cmd("part_lsb", 1'b1, 3'd2, 4'b1100, 1'b0, 1'b0, 4'b0000, 2, 4'b0011);
        release_rsp("part_lsb");

        // Length above WIDTH clamps to WIDTH
        run_cmd("clamp", 1'b0, 3'd7, 4'b0110, 1'b1, 1'b0, 4'b0110, 4, 4'b1111);
        release_rsp("clamp");

        // Backpressure in DONE with a new command pending
        run_cmd("bp", 1'b0, 3'd4, 4'b1001, 1'b0, 1'b0, 4'b1001, 4, 4'b0000);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_len   = 3'd1;
        cmd_data  = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp.rsp_data", 32'(rsp_data), 32'h0);
            check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("bp.idle_ready", 32'(cmd_ready), 32'd1);
        check("bp.idle_nostrobe", 32'(ser_strobe), 32'd0);
        check("bp.idle_data", 32'(rsp_data), 32'h0);
        ser_in = 1'b0;
        tick;
        cmd_valid = 1'b0;
        check("bp.next_strobe", 32'(ser_strobe), 32'd1);
        check("bp.next_ser_out", 32'(ser_out), 32'd0);
        tick;
        check("bp.next_rsp_valid", 32'(rsp_valid), 32'd1);
        check("bp.next_rsp_data", 32'(rsp_data), 32'(4'b1110));
        release_rsp("bp_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
